sha256_byte_host: RTL and testbench

Host-side driver for the byte-serial SHA-256 hasher. A local agent fills a 64-byte message buffer and pulses `start`. The block then streams the bytes to the hasher's load interface as one contiguous strobed burst, waits for the hasher's digest-valid window, and captures the 32 digest bytes into a readable register file. It sits between the on-chip controller/scan logic and the hasher core. It is the transmit end of the hasher's input protocol and the receive end of its output protocol.

---
 rtl/sha256_byte_host_if.sv | 18 +
 rtl/sha256_byte_host.sv | 151 +++++++++++++++
 tb/tb_sha256_byte_host.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_byte_host_if.sv
// Byte-serial hasher link: load strobe/data toward the hasher,
// digest byte/valid back. master = host side, slave = hasher side.
interface sha256_byte_host_if;
  logic [7:0] hs_data;
  logic       hs_strobe;
  logic [7:0] hs_dout;
  logic       hs_dvalid;

  modport master (
    output hs_data, hs_strobe,
    input  hs_dout, hs_dvalid
  );

  modport slave (
    input  hs_data, hs_strobe,
    output hs_dout, hs_dvalid
  );
endinterface

// File: rtl/sha256_byte_host.sv
// Host driver for the byte-serial SHA-256 hasher: buffers a message,
// bursts it on hs, captures the 32-byte digest into a readable file.
module sha256_byte_host #(
  parameter int MAX_MSG_BYTES  = 55,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [5:0]                msg_len,
  input  logic                      wr_en,
  input  logic [5:0]                wr_addr,
  input  logic [7:0]                wr_data,
  sha256_byte_host_if.master        hs,
  input  logic [4:0]                rd_addr,
  output logic [7:0]                rd_data,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CAPTURE
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        len_q, len_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        cap_q, cap_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [63:0][7:0]  buf_q, buf_d;
  logic [31:0][7:0]  dig_q, dig_d;
  logic [7:0]        data_q, data_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              bad_len;

  assign bad_len = (msg_len == 6'd0) ||
                   (32'(msg_len) > MAX_MSG_BYTES);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    tmo_d    = tmo_q;
    buf_d    = buf_q;
    dig_d    = dig_q;
    data_d   = '0;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_en) buf_d[wr_addr] = wr_data;
        if (start) begin
          if (bad_len) begin
            err_d = 2'd1;
          end else begin
            // Output is registered, so byte 0 is issued on the
            // accepting edge; idx then counts bytes already issued.
            err_d    = 2'd0;
            len_d    = msg_len;
            strobe_d = 1'b1;
            data_d   = buf_q[0];
            idx_d    = 6'd1;
            state_d  = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (idx_q == len_q) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          strobe_d = 1'b1;
          data_d   = buf_q[idx_q];
          idx_d    = idx_q + 6'd1;
        end
      end
      S_WAIT: begin
        if (hs.hs_dvalid) begin
          dig_d[0] = hs.hs_dout;
          cap_d    = 6'd1;
          state_d  = S_CAPTURE;
        end else if (tmo_q == TMAX) begin
          err_d   = 2'd2;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        if (hs.hs_dvalid) begin
          dig_d[cap_q[4:0]] = hs.hs_dout;
          cap_d = cap_q + 6'd1;
          if (cap_q == 6'd31) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          err_d   = 2'd3;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      cap_q    <= '0;
      tmo_q    <= '0;
      buf_q    <= '0;
      dig_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      tmo_q    <= tmo_d;
      buf_q    <= buf_d;
      dig_q    <= dig_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign hs.hs_data   = data_q;
  assign hs.hs_strobe = strobe_q;
  assign rd_data      = dig_q[rd_addr];
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sha256_byte_host.sv
// Directed bench for sha256_byte_host: job table plus hand-written
// sequences for timing corners, with a simple hasher model.
module tb_sha256_byte_host;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [5:0] msg_len;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [1:0] err;

  sha256_byte_host_if hif();

  sha256_byte_host #(
    .MAX_MSG_BYTES (55),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .msg_len (msg_len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .hs      (hif),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    int       len;
    int       lat;
    int       ndv;
    int       exp_err;
    int       exp_done;
    bit [7:0] seed;
    bit       abc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit [7:0] sq[$];
  bit [7:0] mbuf[64];
  bit [7:0] sdig[32];
  bit [7:0] fips[32] = '{
    8'hba, 8'h78, 8'h16, 8'hbf, 8'h8f, 8'h01, 8'hcf, 8'hea,
    8'h41, 8'h41, 8'h40, 8'hde, 8'h5d, 8'hae, 8'h22, 8'h23,
    8'hb0, 8'h03, 8'h61, 8'ha3, 8'h96, 8'h17, 8'h7a, 8'h9c,
    8'hb4, 8'h10, 8'hff, 8'h61, 8'hf2, 8'h00, 8'h15, 8'had
  };
  vec_t vt[7];

  always @(negedge clk) begin
    if (hif.hs_strobe) sq.push_back(hif.hs_data);
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input bit [7:0] d);
    wr_addr = 6'(a);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    mbuf[a] = d;
  endtask

  task automatic wait_drop(output int n);
    n = 0;
    while (hif.hs_strobe && n < 80) begin
      tick();
      n++;
    end
    if (hif.hs_strobe) chk("strobe_drop_bound", 1, 0);
  endtask

  task automatic dig_chk(input string nm);
    int nbad = 0;
    for (int k = 0; k < 32; k++) begin
      rd_addr = 5'(k);
      #1;
      if (rd_data != sdig[k]) nbad++;
    end
    chk(nm, nbad, 0);
    tick();
  endtask

  task automatic burst_chk(input string nm, input int len);
    int nbad = 0;
    chk({nm, "_nbytes"}, sq.size(), len);
    for (int i = 0; i < sq.size() && i < 64; i++)
      if (sq[i] != mbuf[i]) nbad++;
    chk({nm, "_bytes"}, nbad, 0);
  endtask

  task automatic feed(input int lat, input int n, input bit [7:0] seed,
                      input bit abc, input bit start_last);
    bit [7:0] b;
    repeat (lat) tick();
    for (int k = 0; k < n; k++) begin
      b = abc ? fips[k] : 8'(seed * 3 + k * 5);
      hif.hs_dout   = b;
      hif.hs_dvalid = 1'b1;
      sdig[k] = b;
      if (start_last && k == n - 1) start = 1'b1;
      tick();
    end
    hif.hs_dvalid = 1'b0;
    hif.hs_dout   = 8'h00;
    if (n == 32) begin
      chk("done_pulse", int'(done), 1);
      chk("busy_fall", int'(busy), 0);
    end
  endtask

  task automatic run_job(input vec_t v);
    int n;
    if (v.exp_err != 1)
      for (int i = 0; i < v.len; i++) wr(i, 8'(v.seed + i));
    sq.delete();
    done_cnt = 0;
    msg_len = 6'(v.len);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (v.exp_err == 1) begin
      chk({v.name, "_busy"}, int'(busy), 0);
      chk({v.name, "_err"}, int'(err), 1);
      repeat (3) tick();
      chk({v.name, "_nostrobe"}, sq.size(), 0);
    end else begin
      chk({v.name, "_errclr"}, int'(err), 0);
      chk({v.name, "_busy"}, int'(busy), 1);
      wait_drop(n);
      chk({v.name, "_width"}, n, v.len);
      chk({v.name, "_data0"}, int'(hif.hs_data), 0);
      burst_chk(v.name, v.len);
      if (v.ndv == 0) begin
        for (int j = 1; j <= 16; j++) begin
          tick();
          if (j == 15) begin
            chk({v.name, "_noerr15"}, int'(err), 0);
            chk({v.name, "_busy15"}, int'(busy), 1);
          end
        end
        chk({v.name, "_err16"}, int'(err), 2);
        chk({v.name, "_idle16"}, int'(busy), 0);
      end else begin
        feed(v.lat, v.ndv, v.seed, v.abc, 1'b0);
      end
      repeat (2) tick();
      chk({v.name, "_err"}, int'(err), v.exp_err);
      chk({v.name, "_idle"}, int'(busy), 0);
      chk({v.name, "_ndone"}, done_cnt, v.exp_done);
      dig_chk({v.name, "_digest"});
    end
  endtask

  function automatic vec_t mk(string nm, int len, int lat, int ndv,
                              int ee, int ed, bit [7:0] seed, bit abc);
    vec_t v;
    v.name = nm; v.len = len; v.lat = lat; v.ndv = ndv;
    v.exp_err = ee; v.exp_done = ed; v.seed = seed; v.abc = abc;
    return v;
  endfunction

  initial begin
    int n;
    vt[0] = mk("abc",     3,  2, 32, 0, 1, 8'h61, 1'b1);
    vt[1] = mk("len0",    0,  0,  0, 1, 0, 8'h00, 1'b0);
    vt[2] = mk("len56",  56,  0,  0, 1, 0, 8'h00, 1'b0);
    vt[3] = mk("max55",  55,  0, 32, 0, 1, 8'h20, 1'b0);
    vt[4] = mk("short",  10,  3, 20, 3, 0, 8'h90, 1'b0);
    vt[5] = mk("tmo",     4,  0,  0, 2, 0, 8'h40, 1'b0);
    vt[6] = mk("lat15",   1, 15, 32, 0, 1, 8'hc3, 1'b0);

    reset_n = 1'b0;
    start = 1'b0; msg_len = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0;
    hif.hs_dout = '0; hif.hs_dvalid = 1'b0;
    foreach (mbuf[i]) mbuf[i] = '0;
    foreach (sdig[i]) sdig[i] = '0;

    repeat (3) tick();
    chk("rst_strobe", int'(hif.hs_strobe), 0);
    chk("rst_data", int'(hif.hs_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    dig_chk("rst_digest");
    reset_n = 1'b1;
    tick();

    for (int t = 0; t < 7; t++) begin
      run_job(vt[t]);
      if (t == 0) begin
        rd_addr = 5'd0; #1;
        chk("abc_byte0", int'(rd_data), 8'hba);
        rd_addr = 5'd31; #1;
        chk("abc_byte31", int'(rd_data), 8'had);
        tick();
      end
    end

    // start/wr_en while busy are ignored
    for (int i = 0; i < 5; i++) wr(i, 8'(8'ha0 + i));
    sq.delete(); done_cnt = 0;
    msg_len = 6'd5; start = 1'b1;
    tick();
    msg_len = 6'd2;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hff;
    tick();
    wr_addr = 6'd4;
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_drop(n);
    burst_chk("rej", 5);
    feed(2, 32, 8'h33, 1'b0, 1'b0);
    repeat (2) tick();
    chk("rej_ndone", done_cnt, 1);
    chk("rej_err", int'(err), 0);

    // start on the final capture edge is ignored, next cycle accepted
    sq.delete();
    msg_len = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_drop(n);
    msg_len = 6'd2;
    feed(1, 32, 8'h77, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    chk("sof_accept", int'(busy), 1);
    wait_drop(n);
    chk("sof_width", n, 2);
    feed(0, 32, 8'h55, 1'b0, 1'b0);
    tick();
    chk("sof_err", int'(err), 0);
    dig_chk("sof_digest");

    // reset in the middle of a 55-byte burst
    msg_len = 6'd55; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_strobe", int'(hif.hs_strobe), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobe", int'(hif.hs_strobe), 0);
    chk("mid_rst_data", int'(hif.hs_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_err", int'(err), 0);
    foreach (mbuf[i]) mbuf[i] = '0;
    foreach (sdig[i]) sdig[i] = '0;
    dig_chk("mid_rst_digest");
    tick();
    reset_n = 1'b1;
    tick();
    run_job(mk("post1", 1, 1, 32, 0, 1, 8'h5a, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
